// File: rtl/shift_add_multiplier.sv
// Sequential shift-and-add multiply-accumulate: product = multiplicand * multiplier + addend.
// start/done handshake; the result is held in the accumulator until the next accepted start.
module shift_add_multiplier #(
    parameter int SIZE = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [SIZE-1:0]   multiplicand,
    input  logic [SIZE-1:0]   multiplier,
    input  logic [SIZE-1:0]   addend,
    output logic [2*SIZE-1:0] product,
    output logic              wide,
    output logic              done,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, CHECK, RUN, DONE} state_t;

    state_t              state, state_next;
    logic [2*SIZE-1:0]   acc;
    logic [2*SIZE-1:0]   mcand_sh;
    logic [SIZE-1:0]     mplier_sh;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CHECK;
            CHECK:   state_next = (mcand_sh == '0 || mplier_sh == '0) ? DONE : RUN;
            RUN:     if (mplier_sh == '0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // RUN stops once the remaining multiplier bits are all zero, so
    // latency tracks the highest set bit of the multiplier.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc       <= '0;
            mcand_sh  <= '0;
            mplier_sh <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    acc       <= {{SIZE{1'b0}}, addend};
                    mcand_sh  <= {{SIZE{1'b0}}, multiplicand};
                    mplier_sh <= multiplier;
                end
                RUN: if (mplier_sh != '0) begin
                    acc       <= acc + (mplier_sh[0] ? mcand_sh : '0);
                    mcand_sh  <= mcand_sh << 1;
                    mplier_sh <= mplier_sh >> 1;
                end
                default: ;
            endcase
        end
    end

    assign product = acc;
    assign wide    = |acc[2*SIZE-1:SIZE];
    assign done    = (state == DONE);
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier (SIZE=32): result values, done latency,
// start-while-busy rejection, back-to-back starts and mid-operation reset.
module tb_shift_add_multiplier;

    localparam int SIZE = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [SIZE-1:0]   multiplicand, multiplier, addend;
    logic [2*SIZE-1:0] product;
    logic              wide, done, busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shift_add_multiplier #(.SIZE(SIZE)) dut (
        .clk(clk), .reset(reset), .start(start),
        .multiplicand(multiplicand), .multiplier(multiplier), .addend(addend),
        .product(product), .wide(wide), .done(done), .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation from IDLE; optionally pulse start with other operands
    // at cycle inj (0 = never). Returns one cycle after done, back in IDLE.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, input logic [63:0] exp_p,
                          input logic exp_w, input int exp_lat, input int inj);
        int lat;
        lat = 0;
        multiplicand = a; multiplier = b; addend = c; start = 1'b1;
        tick();
        start = 1'b0;
        multiplicand = ~a; multiplier = ~b; addend = ~c;
        chk({tag, "_busy_t1"}, 64'(busy), 64'd1);
        if (done) lat = 1;
        for (int n = 2; n <= 50 && lat == 0; n++) begin
            if (n - 1 == inj) begin
                start = 1'b1; multiplicand = 32'd1; multiplier = 32'd1; addend = 32'd1;
            end else begin
                start = 1'b0;
            end
            tick();
            if (done) lat = n;
        end
        start = 1'b0;
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_product"}, product, exp_p);
        chk({tag, "_wide"}, 64'(wide), 64'(exp_w));
        chk({tag, "_busy_done"}, 64'(busy), 64'd1);
        tick();
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
        chk({tag, "_idle"}, 64'(busy), 64'd0);
        chk({tag, "_hold"}, product, exp_p);
    endtask

    initial begin
        int seen;
        reset = 1'b1; start = 1'b0;
        multiplicand = '0; multiplier = '0; addend = '0;
        tick(); tick();
        chk("rst_product", product, 64'd0);
        chk("rst_wide", 64'(wide), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        reset = 1'b0;
        tick();

        run_op("basic", 32'd7, 32'd6, 32'd5, 64'd47, 1'b0, 6, 0);
        run_op("zero_a", 32'd0, 32'd123, 32'd9, 64'd9, 1'b0, 2, 0);
        run_op("zero_b", 32'd123, 32'd0, 32'd9, 64'd9, 1'b0, 2, 0);
        run_op("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               64'hFFFF_FFFF_0000_0000, 1'b1, 35, 0);
        run_op("roundtrip", 32'd14, 32'd7, 32'd2, 64'd100, 1'b0, 6, 0);
        run_op("b_one", 32'd5, 32'd1, 32'd0, 64'd5, 1'b0, 4, 0);
        run_op("b_msb", 32'd3, 32'h8000_0000, 32'd1, 64'h1_8000_0001, 1'b1, 35, 0);
        // start pulsed during RUN is ignored; the next op starts the cycle after done
        run_op("busy_start", 32'd7, 32'd6, 32'd5, 64'd47, 1'b0, 6, 3);
        run_op("after_done", 32'd10, 32'd10, 32'd3, 64'd103, 1'b0, 7, 0);

        // reset asserted during cycle T+3 of the max case
        multiplicand = '1; multiplier = '1; addend = '1; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_product", product, 64'd0);
        chk("mid_rst_wide", 64'(wide), 64'd0);
        seen = 0;
        for (int n = 0; n < 40; n++) begin
            if (done) seen = 1;
            tick();
        end
        chk("mid_rst_no_done", 64'(seen), 64'd0);
        run_op("after_rst", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               64'hFFFF_FFFF_0000_0000, 1'b1, 35, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_add_multiplier.md
# shift_add_multiplier

Sequential shift-and-add multiplier with accumulate, computing `product = multiplicand * multiplier + addend` at full `2*SIZE` precision. It is the inverse datapath to the long-division unit in the arithmetic section. Its main use is reconstructing `quotient * divisor + remainder` for self-check and round-trip paths, and it also serves as a general-purpose MAC. It uses the same start/done handshake as the divider: a one-cycle `done` pulse, with the result held until the next accepted start.

## Interface
- `SIZE`, default 32: operand width in bits; must be ≥ 2.

Ports:
- `clk` in 1: clock; all state updates on rising edge.
- `reset` in 1: reset, synchronous, active-high; clock `clk`.
- `start` in 1: request; sampled only in IDLE.
- `multiplicand` in SIZE: unsigned operand A; sampled on the accepted-start cycle only.
- `multiplier` in SIZE: unsigned operand B; sampled on the accepted-start cycle only.
- `addend` in SIZE: unsigned term C added at bit 0; sampled on the accepted-start cycle only.
- `product` out 2*SIZE: accumulator; valid while `done` is high and held until the next accepted start.
- `wide` out 1: `product[2*SIZE-1:SIZE] != 0`, combinational from the accumulator.
- `done` out 1: one-cycle pulse, Moore output of the DONE state.
- `busy` out 1: high in every state except IDLE.

## Operation
Registers:
- `acc` (2*SIZE): the running product.
- `mcand_sh` (2*SIZE): the multiplicand, shifted left as bits are consumed.
- `mplier_sh` (SIZE): the multiplier, shifted right as bits are consumed.

States:
- **IDLE**
  - If `start`: `acc <= {0, addend}`, `mcand_sh <= {0, multiplicand}`, `mplier_sh <= multiplier`, then go to CHECK.
  - Otherwise stay in IDLE.
- **CHECK**
  - If `mcand_sh == 0` or `mplier_sh == 0`, go to DONE. `acc` still holds `addend`.
  - Otherwise go to RUN.
- **RUN**
  - If `mplier_sh == 0`, go to DONE with no register update.
  - Otherwise:
    - `acc <= acc + (mplier_sh[0] ? mcand_sh : 0)`
    - `mcand_sh <= mcand_sh << 1`
    - `mplier_sh <= mplier_sh >> 1`
    - Stay in RUN.
- **DONE**
  - `done = 1`, then go to IDLE.
- **Unused encodings**
  - Go to IDLE.

Arithmetic rules:
- All operands are unsigned; additions are modulo 2^(2*SIZE).
- The maximum result is (2^SIZE−1)² + (2^SIZE−1) = 2^(2*SIZE) − 2^SIZE, so the result never wraps. No overflow output exists.
- Early termination: RUN ends as soon as the remaining multiplier bits are zero. Latency therefore depends on the highest set bit of `multiplier`, not on its popcount.

Boundary conditions:
- `start` while `busy`: ignored. No reload, no effect on the current operation.
- Operand changes after the accepted-start cycle: ignored.
- `reset` at any time, including mid-RUN:
  - Next cycle: state IDLE, `acc`, `mcand_sh` and `mplier_sh` all 0.
  - `done`, `busy` and `wide` are 0.
  - No `done` pulse is produced for the aborted operation.
- `start` and `reset` in the same cycle: reset wins.
- `start` in the cycle after `done` (state is IDLE): accepted. Back-to-back throughput is therefore (latency + 1) cycles per operation.
- `product` is not cleared by a new start until the load edge.

## Timing
Let `start` be sampled high in IDLE during cycle T.

- Reset values: `product = 0`, `wide = 0`, `done = 0`, `busy = 0`.
- `busy` is high from cycle T+1 through the DONE cycle, inclusive.
- Zero shortcut (A == 0 or B == 0): CHECK at T+1, `done` at T+2.
- General case, where k is the index of the highest set bit of B:
  - CHECK at T+1.
  - RUN update cycles T+2 .. T+2+k.
  - Exit cycle T+3+k.
  - `done` at T+4+k.
- Worst case (k = SIZE−1): `done` at T+SIZE+3, which is T+35 for SIZE=32.
- `product` and `wide` are valid and stable from the first DONE cycle until the load edge of the next accepted start.

## Test plan
- **Basic:** A=7, B=6, C=5 at T → `done` only at T+6, `product=47`, `wide=0`, `busy` high T+1..T+6.
- **Zero shortcut:** A=0, B=123, C=9 → `done` at T+2, `product=9`. Repeat with A=123, B=0 → same result and timing.
- **Max width (SIZE=32):** A=B=C=0xFFFFFFFF → `done` at T+35, `product=0xFFFFFFFF_00000000`, `wide=1`.
- **Divider round-trip:** divider on 100/7 gives q=14, r=2; feed A=14, B=7, C=2 → `product=100`, `wide=0`, `done` at T+6.
- **Start while busy:**
  - Assert `start` with new operands during RUN → ignored; the original result completes unchanged.
  - Then assert `start` in the cycle after `done` → accepted, with correct second result and latency.
- **Reset mid-operation:** assert `reset` at T+3 of the A=B=C=0xFFFFFFFF case → next cycle `busy=0`, `product=0`, and no `done` pulse ever appears. A fresh start then yields the correct result.
